// File: rtl/gesummv_pkg.sv
// Shared gesummv definitions: collector FSM states and default problem sizes.
package gesummv_pkg;

  localparam int unsigned GESUMMV_N      = 8;
  localparam int unsigned GESUMMV_ADDR_W = 3;
  localparam int unsigned GESUMMV_DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    DRAIN   = 2'd2
  } state_t;

endpackage

// File: rtl/gesummv_y_collector.sv
// Captures the gesummv y vector from the kernel memory port and replays it in address order.
// Optional: GESUMMV_Y_COLLECTOR_CYCLE_COUNT_EN adds a saturating CAPTURE-length counter.
module gesummv_y_collector
  import gesummv_pkg::*;
#(
  parameter int unsigned DEPTH  = GESUMMV_N,
  parameter int unsigned ADDR_W = GESUMMV_ADDR_W,
  parameter int unsigned DATA_W = GESUMMV_DATA_W
) (
  input  logic              ap_clk,
  input  logic              ap_rst_n,
  input  logic              ap_start,
  input  logic              ap_done,
  input  logic              y_ce0,
  input  logic              y_we0,
  input  logic [ADDR_W-1:0] y_address0,
  input  logic [DATA_W-1:0] y_d0,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [ADDR_W-1:0] out_index,
  output logic              out_last,
  output logic              busy,
  output logic              dup_err,
  output logic              miss_err,
`ifdef GESUMMV_Y_COLLECTOR_CYCLE_COUNT_EN
  output logic [31:0]       cycle_count,
`endif
  output logic              stray_err
);

  localparam logic [ADDR_W:0]   DEPTH_W  = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH-1);

  state_t             state;
  logic [DATA_W-1:0]  ybuf [DEPTH];
  logic [DEPTH-1:0]   mask;
  logic [ADDR_W-1:0]  idx;

  logic               wr_req, in_rng, cap_wr;
  logic [DEPTH-1:0]   wr_oh;

  assign wr_req = y_ce0 & y_we0;
  assign in_rng = {1'b0, y_address0} < DEPTH_W;
  assign cap_wr = (state == CAPTURE) && wr_req && in_rng;

  // One-hot of the current write so coverage can include a same-cycle write on ap_done
  always_comb begin
    wr_oh = '0;
    if (cap_wr) wr_oh[y_address0] = 1'b1;
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state    <= IDLE;
      mask     <= '0;
      idx      <= '0;
      dup_err  <= 1'b0;
      miss_err <= 1'b0;
      for (int i = 0; i < int'(DEPTH); i++) ybuf[i] <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (ap_start) begin
            state    <= CAPTURE;
            mask     <= '0;
            dup_err  <= 1'b0;
            miss_err <= 1'b0;
            for (int i = 0; i < int'(DEPTH); i++) ybuf[i] <= '0;
          end
        end
        CAPTURE: begin
          if (cap_wr) begin
            ybuf[y_address0] <= y_d0;
            mask[y_address0] <= 1'b1;
            if (mask[y_address0]) dup_err <= 1'b1;
          end
          if (ap_done) begin
            state <= DRAIN;
            idx   <= '0;
            if (!(&(mask | wr_oh))) miss_err <= 1'b1;
          end
        end
        DRAIN: begin
          if (out_ready) begin
            if (idx == LAST_IDX) begin
              state <= IDLE;
              idx   <= '0;
            end else begin
              idx <= idx + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Anything the kernel writes outside CAPTURE, or past DEPTH, is dropped and flagged until reset
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n)                                  stray_err <= 1'b0;
    else if (wr_req && (state != CAPTURE || !in_rng)) stray_err <= 1'b1;
  end

`ifdef GESUMMV_Y_COLLECTOR_CYCLE_COUNT_EN
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n)                           cycle_count <= '0;
    else if (state == IDLE && ap_start)      cycle_count <= '0;
    else if (state == CAPTURE && !(&cycle_count)) cycle_count <= cycle_count + 32'd1;
  end
`endif

  // Buffer is frozen during DRAIN, so these decodes of registered state are stable under stall
  assign out_valid = (state == DRAIN);
  assign out_data  = ybuf[idx];
  assign out_index = idx;
  assign out_last  = out_valid && (idx == LAST_IDX);
  assign busy      = (state != IDLE);

endmodule
